demux1a4_tdm: RTL

//  Receive-side counterpart of the 4:1 channel multiplexer: a time-division
//  1-to-4 demultiplexer. One shared input line carries channels a,b,c,d in

---
 rtl/demux1a4_tdm.sv | 83 ++++++++
 1 files changed

// File: rtl/demux1a4_tdm.sv
// demux1a4_tdm: time-division 1-to-4 demultiplexer with frame-coherent outputs.
// Ports: clk, rst_n, in/valid/sync (TDM line in), outa..outd, S, frame_ok, err, frame_cnt.
module demux1a4_tdm #(
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in,
  input  logic          valid,
  input  logic          sync,
  output logic [W-1:0]  outa,
  output logic [W-1:0]  outb,
  output logic [W-1:0]  outc,
  output logic [W-1:0]  outd,
  output logic [1:0]    S,
  output logic          frame_ok,
  output logic          err,
  output logic [CW-1:0] frame_cnt
);

  logic [1:0]    s_q;
  logic [W-1:0]  stg0_q, stg1_q, stg2_q;
  logic [W-1:0]  outa_q, outb_q, outc_q, outd_q;
  logic          ok_q, err_q;
  logic [CW-1:0] cnt_q;

  // sync on a non-zero slot restarts the frame at slot 0
  logic resync;
  assign resync = valid && sync && (s_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      stg0_q <= '0;
      stg1_q <= '0;
      stg2_q <= '0;
      outa_q <= '0;
      outb_q <= '0;
      outc_q <= '0;
      outd_q <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (resync) begin
        stg0_q <= in;
        stg1_q <= '0;
        stg2_q <= '0;
        s_q    <= 2'd1;
        err_q  <= 1'b1;
      end else if (valid) begin
        s_q <= s_q + 2'd1;
        unique case (s_q)
          2'd0: stg0_q <= in;
          2'd1: stg1_q <= in;
          2'd2: stg2_q <= in;
          2'd3: begin
            outa_q <= stg0_q;
            outb_q <= stg1_q;
            outc_q <= stg2_q;
            outd_q <= in;
            cnt_q  <= cnt_q + 1'b1;
            ok_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign outa      = outa_q;
  assign outb      = outb_q;
  assign outc      = outc_q;
  assign outd      = outd_q;
  assign S         = s_q;
  assign frame_ok  = ok_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule
